// File: rtl/fft_frame_buffer.sv
//==============================================================================
// Module      : fft_frame_buffer
// Description : Ping-pong frame buffer between the serial input stage and the
//               FFT core. Packs N samples per bank and presents full banks to
//               the core through a ready/ack handshake and a registered
//               random-access read port.
//               Optional macro FFT_BUF_BITREV_EN: when defined, samples are
//               stored at the bit-reversed address of their index; when
//               undefined, samples are stored in natural order.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fft_frame_buffer #(
    parameter int N     = 16,
    parameter int LOG2N = 4,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_req,
    output logic             in_ans,
    input  logic [DW-1:0]    in_data,
    output logic             frm_rdy,
    output logic             frm_bank,
    input  logic             frm_ack,
    input  logic [LOG2N-1:0] rd_addr,
    output logic [DW-1:0]    rd_data,
    output logic [LOG2N:0]   fill_cnt,
    output logic             ovf
);

    typedef enum logic [1:0] {
        B_EMPTY   = 2'd0,
        B_FILLING = 2'd1,
        B_FULL    = 2'd2
    } bank_st_t;

    typedef enum logic {
        W_FILL  = 1'b0,
        W_STALL = 1'b1
    } wr_st_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rd_st_t;

    localparam logic [LOG2N:0] C_LAST = (LOG2N+1)'(N - 1);

    bank_st_t         r_bank_st [2];
    wr_st_t           r_wr_st;
    rd_st_t           r_rd_st;
    logic             r_wr_bank;
    logic [LOG2N:0]   r_wr_cnt;
    logic             r_in_ans;
    logic             r_rd_ptr;
    logic             r_frm_rdy;
    logic             r_frm_bank;
    logic             r_ovf;
    logic [DW-1:0]    r_rd_data;
    logic [DW-1:0]    r_mem [0:2*N-1];

    logic             w_xfer;
    logic             w_ack;
    logic             w_last;
    logic             w_nxt_free;
    logic             w_cur_free;
    logic [LOG2N-1:0] w_wr_addr;

    assign w_xfer = in_req & r_in_ans;
    assign w_ack  = frm_ack & r_frm_rdy;
    assign w_last = w_xfer && (r_wr_cnt == C_LAST);

    // A bank being acked this cycle counts as free, so a coincident ack and
    // frame completion never costs a stall cycle.
    assign w_nxt_free = (r_bank_st[~r_wr_bank] == B_EMPTY) ||
                        (w_ack && (r_frm_bank == ~r_wr_bank));
    assign w_cur_free = (r_bank_st[r_wr_bank] == B_EMPTY) ||
                        (w_ack && (r_frm_bank == r_wr_bank));

    generate
`ifdef FFT_BUF_BITREV_EN
        for (genvar i = 0; i < LOG2N; i++) begin : g_bitrev
            assign w_wr_addr[i] = r_wr_cnt[LOG2N-1-i];
        end
`else
        if (1) begin : g_natural
            assign w_wr_addr = r_wr_cnt[LOG2N-1:0];
        end
`endif
    endgenerate

    // Bank occupancy: the writer fills/completes banks, the reader frees them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank_st[0] <= B_EMPTY;
            r_bank_st[1] <= B_EMPTY;
        end else if (clr) begin
            r_bank_st[0] <= B_EMPTY;
            r_bank_st[1] <= B_EMPTY;
        end else begin
            if (w_xfer) begin
                r_bank_st[r_wr_bank] <= w_last ? B_FULL : B_FILLING;
            end
            if (w_ack) begin
                r_bank_st[r_frm_bank] <= B_EMPTY;
            end
        end
    end

    // Write FSM: counts samples into the filling bank, stalls when both banks are taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_st   <= W_FILL;
            r_in_ans  <= 1'b1;
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
        end else if (clr) begin
            r_wr_st   <= W_FILL;
            r_in_ans  <= 1'b1;
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
        end else begin
            case (r_wr_st)
                W_FILL: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_wr_cnt  <= '0;
                            r_wr_bank <= ~r_wr_bank;
                            if (!w_nxt_free) begin
                                r_wr_st  <= W_STALL;
                                r_in_ans <= 1'b0;
                            end
                        end else begin
                            r_wr_cnt <= r_wr_cnt + 1'b1;
                        end
                    end
                end
                W_STALL: begin
                    if (w_cur_free) begin
                        r_wr_st  <= W_FILL;
                        r_in_ans <= 1'b1;
                    end
                end
                default: begin
                    r_wr_st  <= W_FILL;
                    r_in_ans <= 1'b1;
                end
            endcase
        end
    end

    // Read FSM: presents banks in fill order; leaves a one-cycle gap after each ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_st    <= R_IDLE;
            r_rd_ptr   <= 1'b0;
            r_frm_rdy  <= 1'b0;
            r_frm_bank <= 1'b0;
        end else if (clr) begin
            r_rd_st    <= R_IDLE;
            r_rd_ptr   <= 1'b0;
            r_frm_rdy  <= 1'b0;
            r_frm_bank <= 1'b0;
        end else begin
            case (r_rd_st)
                R_IDLE: begin
                    if (r_bank_st[r_rd_ptr] == B_FULL) begin
                        r_rd_st    <= R_BUSY;
                        r_frm_rdy  <= 1'b1;
                        r_frm_bank <= r_rd_ptr;
                    end
                end
                R_BUSY: begin
                    if (w_ack) begin
                        r_rd_st   <= R_IDLE;
                        r_frm_rdy <= 1'b0;
                        r_rd_ptr  <= ~r_rd_ptr;
                    end
                end
                default: begin
                    r_rd_st   <= R_IDLE;
                    r_frm_rdy <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: upstream offered a sample while we could not accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end else if (in_req && !r_in_ans) begin
            r_ovf <= 1'b1;
        end
    end

    // Sample storage: one write port, contents survive reset.
    always_ff @(posedge clk) begin
        if (w_xfer && !clr) begin
            r_mem[{r_wr_bank, w_wr_addr}] <= in_data;
        end
    end

    // Registered read port into the presented bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (clr) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[{r_frm_bank, rd_addr}];
        end
    end

    assign in_ans   = r_in_ans;
    assign frm_rdy  = r_frm_rdy;
    assign frm_bank = r_frm_bank;
    assign rd_data  = r_rd_data;
    assign fill_cnt = r_wr_cnt;
    assign ovf      = r_ovf;

endmodule

`default_nettype wire
